seq_multiplier_sm: RTL and testbench
====================================

Name: seq_multiplier_sm

Overview:
Parametrised sequential shift-add multiplier, successor to the fixed 4-bit unit: N-bit operands, 2N-bit product, run-time selectable unsigned or two's-complement mode. Keeps the shared-bus LOADB/LOADQ/G load-then-start interface. Adds BUSY, a registered result that holds stable across operations, and defined behaviour for every collision.

Parameters:
N, 4, operand width in bits; legal range 2..32.
CW, $clog2(N+1), step counter width; derived, not overridden.

Ports:
CLK  in  1  system clock, rising edge.
RESET_N  in  1  asynchronous active-low reset.
G  in  1  start pulse; sampled in IDLE only.
LOADB  in  1  load multiplicand B from MULT_IN.
LOADQ  in  1  load multiplier Q from MULT_IN.
MULT_IN  in  N  operand input bus.
SIGNED_MODE  in  1  0 = unsigned, 1 = two's complement; sampled with an accepted G.
MULT_OUT  out  2N  registered product of the last completed operation.
MULT_FINISH  out  1  level; high from completion until the next accepted G or load.
BUSY  out  1  high while the multiply runs.

Behaviour:
- Reset: asynchronous assert, synchronous release. State = IDLE; B, Q, A, counter, MULT_OUT = 0; MULT_FINISH = 0; BUSY = 0.
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever written to MULT_OUT.
- States:
  - IDLE: waits for a command.
  - RUN: N iterations, one per clock.
  - DONE: one cycle to write the result.
- IDLE:
  - LOADB = 1 → B <= MULT_IN. LOADQ = 1 → Q <= MULT_IN. Both = 1 → both registers take MULT_IN.
  - Any load clears MULT_FINISH.
  - If a load and G are high in the same cycle, the load wins and G is ignored.
  - G = 1 with no load → latch mode, A <= 0, counter <= N, MULT_FINISH <= 0, go to RUN.
- RUN:
  - A is N+1 bits.
  - Each cycle, if Q[0] = 1: A <= A + ext(B). In signed mode, the final iteration (counter = 1) uses A - ext(B).
  - ext() is zero-extension in unsigned mode, sign-extension in signed mode.
  - Then {A,Q} shifts right by 1. The bit shifted into A[N] is 0 in unsigned mode and A[N] (arithmetic shift) in signed mode.
  - counter decrements; leave RUN when it reaches 0.
- DONE: MULT_OUT <= {A[N-1:0], Q}; MULT_FINISH <= 1; go to IDLE.
- Latency: G sampled at edge k → MULT_FINISH = 1 and MULT_OUT valid after edge k+N+1.
- BUSY = 1 in RUN and DONE.
- G, LOADB, LOADQ and SIGNED_MODE are ignored while BUSY.
- MULT_OUT changes only in DONE and on reset.
- No overflow is possible: the product always fits 2N bits in both modes.

Decomposition:
- Shared package mult_pkg:
  - state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - MODE_UNSIGNED / MODE_SIGNED constants.
- One natural sub-module, mult_datapath: B/Q/A registers, add/sub, shifter.
- The parent holds the FSM and counter and drives load/init/step/commit strobes.

Test Plan:
- N=4 unsigned: LOADB 3, LOADQ 2, G → after N+1 = 5 cycles, MULT_FINISH = 1, MULT_OUT = 8'd6. Then 15×15 → 8'd225; MULT_OUT holds 6 until that DONE.
- N=4 signed: B = 4'b1000 (-8), Q = 4'b0111 (7) → MULT_OUT = 8'hC8 (-56). Then -8×-8 → 8'h40. Then -1×-1 → 8'h01.
- Collision, N=4:
  - G pulsed while BUSY → no restart.
  - LOADB 9 while BUSY → B unchanged; result of the running 3×2 is still 6.
  - LOADQ and G in the same IDLE cycle → Q loaded, no start.
- Reset mid-run: assert RESET_N = 0 two cycles after G during 7×5 → MULT_OUT = 0, MULT_FINISH = 0, BUSY = 0 at once; after release, 7×5 → 8'd35.
- N=8 instance:
  - 255×255 unsigned → 16'd65025 after 9 cycles.
  - -128×-128 signed → 16'h4000.
  - -128×127 signed → 16'hC080.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier:
// FSM state encoding and operand-mode selectors.
package mult_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/seq_multiplier_sm_if.sv
// Shared load/start bus and result signals of the
// sequential multiplier; master drives, slave is the unit.
interface seq_multiplier_sm_if #(
  parameter int N = 4
);

  logic           G;
  logic           LOADB;
  logic           LOADQ;
  logic           SIGNED_MODE;
  logic [N-1:0]   MULT_IN;
  logic [2*N-1:0] MULT_OUT;
  logic           MULT_FINISH;
  logic           BUSY;

  modport master (
    output G,
    output LOADB,
    output LOADQ,
    output SIGNED_MODE,
    output MULT_IN,
    input  MULT_OUT,
    input  MULT_FINISH,
    input  BUSY
  );

  modport slave (
    input  G,
    input  LOADB,
    input  LOADQ,
    input  SIGNED_MODE,
    input  MULT_IN,
    output MULT_OUT,
    output MULT_FINISH,
    output BUSY
  );

endinterface

// File: rtl/mult_datapath.sv
// B/Q/A registers, add/subtract and the {A,Q} right shifter,
// plus the product register written only on commit.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_b,
  input  logic           load_q,
  input  logic           init,
  input  logic           step,
  input  logic           last,
  input  logic           commit,
  input  logic           mode_in,
  input  logic [N-1:0]   din,
  output logic [2*N-1:0] product
);

  logic [N-1:0] b;
  logic [N-1:0] q;
  logic [N:0]   a;
  logic [N:0]   ext_b;
  logic [N:0]   sum;
  logic         mode;
  logic         shift_in;

  // Signed mode subtracts on the last step: Q's MSB has weight -2^(N-1).
  always_comb begin
    ext_b = (mode == MODE_SIGNED) ? {b[N-1], b} : {1'b0, b};
    sum   = a;
    if (q[0]) begin
      if (mode == MODE_SIGNED && last)
        sum = a - ext_b;
      else
        sum = a + ext_b;
    end
    shift_in = (mode == MODE_SIGNED) ? sum[N] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b       <= '0;
      q       <= '0;
      a       <= '0;
      mode    <= MODE_UNSIGNED;
      product <= '0;
    end else begin
      if (load_b)
        b <= din;
      if (load_q)
        q <= din;
      if (init) begin
        a    <= '0;
        mode <= mode_in;
      end
      if (step) begin
        a <= {shift_in, sum[N:1]};
        q <= {sum[0], q[N-1:1]};
      end
      if (commit)
        product <= {a[N-1:0], q};
    end
  end

endmodule

// File: rtl/seq_multiplier_sm.sv
// Sequential N-bit shift-add multiplier: FSM and step counter,
// driving load/init/step/commit strobes into the datapath.
module seq_multiplier_sm
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input logic             CLK,
  input logic             RESET_N,
  seq_multiplier_sm_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          finish;
  logic          idle;
  logic          any_load;
  logic          start;
  logic          step;
  logic          last;
  logic          commit;

  assign idle     = (state == S_IDLE);
  assign any_load = idle & (bus.LOADB | bus.LOADQ);
  // A load in the same cycle as G takes priority; G is dropped.
  assign start    = idle & bus.G & ~(bus.LOADB | bus.LOADQ);
  assign step     = (state == S_RUN);
  assign last     = (cnt == CW'(1));
  assign commit   = (state == S_DONE);

  assign bus.BUSY        = ~idle;
  assign bus.MULT_FINISH = finish;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      finish <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any_load) begin
            finish <= 1'b0;
          end else if (start) begin
            finish <= 1'b0;
            cnt    <= N_CNT;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt - CW'(1);
          if (last)
            state <= S_DONE;
        end
        S_DONE: begin
          finish <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mult_datapath #(
    .N(N)
  ) u_dp (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .load_b  (idle & bus.LOADB),
    .load_q  (idle & bus.LOADQ),
    .init    (start),
    .step    (step),
    .last    (last),
    .commit  (commit),
    .mode_in (bus.SIGNED_MODE),
    .din     (bus.MULT_IN),
    .product (bus.MULT_OUT)
  );

endmodule

// File: tb/tb_seq_multiplier_sm.sv
// Self-checking bench for seq_multiplier_sm: N=4 and N=8 instances
// against an integer-arithmetic reference product.
module tb_seq_multiplier_sm;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_multiplier_sm_if #(.N(4)) if4 ();
  seq_multiplier_sm_if #(.N(8)) if8 ();

  seq_multiplier_sm #(.N(4)) dut4 (
    .CLK(clk), .RESET_N(rst_n), .bus(if4)
  );
  seq_multiplier_sm #(.N(8)) dut8 (
    .CLK(clk), .RESET_N(rst_n), .bus(if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input int n, input logic [31:0] b,
    input logic [31:0] q, input bit sgn
  );
    longint bv, qv, p;
    int sh;
    sh = 64 - n;
    bv = longint'({32'b0, b});
    qv = longint'({32'b0, q});
    if (sgn) begin
      bv = (bv << sh) >>> sh;
      qv = (qv << sh) >>> sh;
    end
    p = bv * qv;
    return 64'(p) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  task automatic load4(input logic [3:0] b, input logic [3:0] q);
    if4.LOADB = 1'b1; if4.MULT_IN = b;
    @(negedge clk);
    if4.LOADB = 1'b0; if4.LOADQ = 1'b1; if4.MULT_IN = q;
    @(negedge clk);
    if4.LOADQ = 1'b0;
  endtask

  task automatic start4(input bit s);
    if4.G = 1'b1; if4.SIGNED_MODE = s;
    @(negedge clk);
    if4.G = 1'b0; if4.SIGNED_MODE = 1'b0;
  endtask

  task automatic wait4(output int cyc);
    cyc = 0;
    while (!if4.MULT_FINISH && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run8(
    input logic [7:0] b, input logic [7:0] q,
    input bit s, output int cyc
  );
    if8.LOADB = 1'b1; if8.MULT_IN = b;
    @(negedge clk);
    if8.LOADB = 1'b0; if8.LOADQ = 1'b1; if8.MULT_IN = q;
    @(negedge clk);
    if8.LOADQ = 1'b0;
    if8.G = 1'b1; if8.SIGNED_MODE = s;
    @(negedge clk);
    if8.G = 1'b0; if8.SIGNED_MODE = 1'b0;
    cyc = 0;
    while (!if8.MULT_FINISH && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (if4.MULT_OUT !== 8'h00 || if4.MULT_FINISH !== 1'b0 ||
        if4.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset4: out=%h fin=%b busy=%b want 00/0/0",
               if4.MULT_OUT, if4.MULT_FINISH, if4.BUSY);
    end
    checks++;
    if (if8.MULT_OUT !== 16'h0000 || if8.MULT_FINISH !== 1'b0 ||
        if8.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset8: out=%h fin=%b busy=%b want 0000/0/0",
               if8.MULT_OUT, if8.MULT_FINISH, if8.BUSY);
    end
  endtask

  task automatic test_unsigned;
    int cyc;
    logic [63:0] exp;
    load4(4'd3, 4'd2);
    start4(1'b0);
    checks++;
    if (if4.BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_run: got %b want 1", if4.BUSY);
    end
    wait4(cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("FAIL latency4: got %0d want 5", cyc);
    end
    checks++;
    if (if4.MULT_OUT !== 8'd6) begin
      errors++;
      $display("FAIL u3x2: got %0d want 6", if4.MULT_OUT);
    end
    load4(4'd15, 4'd15);
    checks++;
    if (if4.MULT_FINISH !== 1'b0) begin
      errors++;
      $display("FAIL load_clr_fin: got %b want 0", if4.MULT_FINISH);
    end
    start4(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (if4.MULT_OUT !== 8'd6) begin
      errors++;
      $display("FAIL hold_out: got %0d want 6", if4.MULT_OUT);
    end
    wait4(cyc);
    checks++;
    if (if4.MULT_OUT !== 8'd225) begin
      errors++;
      $display("FAIL u15x15: got %0d want 225", if4.MULT_OUT);
    end
  endtask

  task automatic test_signed;
    int cyc;
    load4(4'b1000, 4'b0111);
    start4(1'b1);
    wait4(cyc);
    checks++;
    if (if4.MULT_OUT !== 8'hC8) begin
      errors++;
      $display("FAIL s-8x7: got %h want c8", if4.MULT_OUT);
    end
    load4(4'b1000, 4'b1000);
    start4(1'b1);
    wait4(cyc);
    checks++;
    if (if4.MULT_OUT !== 8'h40) begin
      errors++;
      $display("FAIL s-8x-8: got %h want 40", if4.MULT_OUT);
    end
    load4(4'hF, 4'hF);
    start4(1'b1);
    wait4(cyc);
    checks++;
    if (if4.MULT_OUT !== 8'h01) begin
      errors++;
      $display("FAIL s-1x-1: got %h want 01", if4.MULT_OUT);
    end
  endtask

  task automatic test_random4;
    int cyc;
    logic [3:0] b, q;
    bit s;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      b = 4'($urandom_range(0, 15));
      q = 4'($urandom_range(0, 15));
      s = 1'($urandom_range(0, 1));
      exp = ref_mul(4, {28'b0, b}, {28'b0, q}, s);
      load4(b, q);
      start4(s);
      wait4(cyc);
      checks++;
      if (if4.MULT_OUT !== exp[7:0] || cyc != 5) begin
        errors++;
        $display("FAIL rnd4 %h*%h s=%b: got %h/%0d want %h/5",
                 b, q, s, if4.MULT_OUT, cyc, exp[7:0]);
      end
    end
  endtask

  task automatic test_collision;
    int cyc;
    load4(4'd3, 4'd2);
    start4(1'b0);
    if4.G = 1'b1; if4.LOADB = 1'b1; if4.MULT_IN = 4'd9;
    @(negedge clk);
    if4.G = 1'b0; if4.LOADB = 1'b0;
    wait4(cyc);
    checks++;
    if (cyc != 4 || if4.MULT_OUT !== 8'd6) begin
      errors++;
      $display("FAIL busy_ignore: got %0d/%0d want 6/4",
               if4.MULT_OUT, cyc);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (if4.BUSY !== 1'b0 || if4.MULT_FINISH !== 1'b1) begin
      errors++;
      $display("FAIL no_restart: busy=%b fin=%b want 0/1",
               if4.BUSY, if4.MULT_FINISH);
    end
    if4.LOADQ = 1'b1; if4.G = 1'b1; if4.MULT_IN = 4'd5;
    @(negedge clk);
    if4.LOADQ = 1'b0; if4.G = 1'b0;
    @(negedge clk);
    checks++;
    if (if4.BUSY !== 1'b0 || if4.MULT_FINISH !== 1'b0) begin
      errors++;
      $display("FAIL load_wins: busy=%b fin=%b want 0/0",
               if4.BUSY, if4.MULT_FINISH);
    end
    start4(1'b0);
    wait4(cyc);
    checks++;
    if (if4.MULT_OUT !== 8'd15) begin
      errors++;
      $display("FAIL b_kept: got %0d want 15", if4.MULT_OUT);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    load4(4'd7, 4'd5);
    start4(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (if4.MULT_OUT !== 8'd0 || if4.MULT_FINISH !== 1'b0 ||
        if4.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort: out=%h fin=%b busy=%b want 00/0/0",
               if4.MULT_OUT, if4.MULT_FINISH, if4.BUSY);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load4(4'd7, 4'd5);
    start4(1'b0);
    wait4(cyc);
    checks++;
    if (if4.MULT_OUT !== 8'd35) begin
      errors++;
      $display("FAIL after_rst: got %0d want 35", if4.MULT_OUT);
    end
  endtask

  task automatic test_n8;
    int cyc;
    logic [7:0] b, q;
    bit s;
    logic [63:0] exp;
    run8(8'd255, 8'd255, 1'b0, cyc);
    checks++;
    if (if8.MULT_OUT !== 16'd65025 || cyc != 9) begin
      errors++;
      $display("FAIL u255sq: got %0d/%0d want 65025/9",
               if8.MULT_OUT, cyc);
    end
    run8(8'h80, 8'h80, 1'b1, cyc);
    checks++;
    if (if8.MULT_OUT !== 16'h4000) begin
      errors++;
      $display("FAIL s-128sq: got %h want 4000", if8.MULT_OUT);
    end
    run8(8'h80, 8'h7F, 1'b1, cyc);
    checks++;
    if (if8.MULT_OUT !== 16'hC080) begin
      errors++;
      $display("FAIL s-128x127: got %h want c080", if8.MULT_OUT);
    end
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      q = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      exp = ref_mul(8, {24'b0, b}, {24'b0, q}, s);
      run8(b, q, s, cyc);
      checks++;
      if (if8.MULT_OUT !== exp[15:0] || cyc != 9) begin
        errors++;
        $display("FAIL rnd8 %h*%h s=%b: got %h/%0d want %h/9",
                 b, q, s, if8.MULT_OUT, cyc, exp[15:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if4.G = 1'b0; if4.LOADB = 1'b0; if4.LOADQ = 1'b0;
    if4.SIGNED_MODE = 1'b0; if4.MULT_IN = '0;
    if8.G = 1'b0; if8.LOADB = 1'b0; if8.LOADQ = 1'b0;
    if8.SIGNED_MODE = 1'b0; if8.MULT_IN = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed();
    test_random4();
    test_collision();
    test_reset_midrun();
    test_n8();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
